// File: rtl/mem_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_pkg;

  localparam int unsigned BLK_W       = 64;
  localparam int unsigned MEM_LAT_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    IREAD,
    DREAD,
    DWRITE,
    DONE
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-command signals of the unified-memory arbiter.
interface mem_arbiter_if
  import mem_pkg::*;
#(
  parameter int unsigned BLK_AW = 14
) ();

  logic              i_req;
  logic [BLK_AW-1:0] i_addr;
  logic              i_rdy;
  logic              d_req;
  logic              d_we;
  logic [BLK_AW-1:0] d_addr;
  logic [BLK_W-1:0]  d_wdata;
  logic              d_rdy;
  logic [BLK_W-1:0]  rd_data;
  logic              mem_re;
  logic              mem_we;
  logic [BLK_AW-1:0] mem_addr;
  logic [BLK_W-1:0]  mem_wdata;
  logic [BLK_W-1:0]  mem_rdata;
  logic              busy;

  // Arbiter side.
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_rdy, d_rdy, rd_data, mem_re, mem_we, mem_addr, mem_wdata, busy
  );

  // Requesters and memory, seen from outside the arbiter.
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_rdy, d_rdy, rd_data, mem_re, mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing a fixed-latency single-ported block memory
// between the I-cache fill controller and the D-cache miss/write-back controller.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned MEM_LAT = MEM_LAT_DEF,
  parameter int unsigned BLK_AW  = 14
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int unsigned     CNT_W    = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  state_t             state;
  owner_t             last_grant;
  owner_t             owner;
  logic [CNT_W-1:0]   cnt;
  logic [BLK_AW-1:0]  addr_q;
  logic [BLK_W-1:0]   wdata_q;
  logic [BLK_W-1:0]   rd_data_q;
  logic               i_rdy_q;
  logic               d_rdy_q;
  logic               mem_re_q;
  logic               mem_we_q;
  logic               busy_q;
  logic               grant_d_c;

  // D wins when alone, or on a tie when I was served last.
  assign grant_d_c = bus.d_req && (!bus.i_req || (last_grant == OWN_I));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= OWN_I;
      owner      <= OWN_I;
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      i_rdy_q    <= 1'b0;
      d_rdy_q    <= 1'b0;
      mem_re_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      i_rdy_q <= 1'b0;
      d_rdy_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.i_req || bus.d_req) begin
            busy_q <= 1'b1;
            cnt    <= '0;
            if (grant_d_c) begin
              owner      <= OWN_D;
              last_grant <= OWN_D;
              addr_q     <= bus.d_addr;
              if (bus.d_we) begin
                state    <= DWRITE;
                mem_we_q <= 1'b1;
                wdata_q  <= bus.d_wdata;
              end else begin
                state    <= DREAD;
                mem_re_q <= 1'b1;
              end
            end else begin
              owner      <= OWN_I;
              last_grant <= OWN_I;
              addr_q     <= bus.i_addr;
              state      <= IREAD;
              mem_re_q   <= 1'b1;
            end
          end
        end
        IREAD, DREAD, DWRITE: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            state    <= DONE;
            mem_re_q <= 1'b0;
            mem_we_q <= 1'b0;
            // Read data is only valid in the final command cycle.
            if (state != DWRITE) begin
              rd_data_q <= bus.mem_rdata;
            end
            if (owner == OWN_I) begin
              i_rdy_q <= 1'b1;
            end else begin
              d_rdy_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          mem_re_q <= 1'b0;
          mem_we_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.i_rdy     = i_rdy_q;
  assign bus.d_rdy     = d_rdy_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: MEM_LAT=4 main instance plus a MEM_LAT=1 build.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   re_cnt4;
  int   re_cnt1;

  mem_arbiter_if #(.BLK_AW(14)) bus4 ();
  mem_arbiter_if #(.BLK_AW(14)) bus1 ();

  mem_arbiter #(.MEM_LAT(4), .BLK_AW(14)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  mem_arbiter #(.MEM_LAT(1), .BLK_AW(14)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: one fixed block at 0x0002, an address-derived pattern elsewhere.
  function automatic logic [63:0] pat(input logic [13:0] a);
    if (a == 14'h0002) return 64'h1112_C4FF_0332_0000;
    return {2'b10, a, 2'b01, a, 2'b11, a, 2'b00, a};
  endfunction

  // Read data is driven only in the last cycle of a read command; garbage otherwise.
  always @(posedge clk) re_cnt4 <= bus4.mem_re ? re_cnt4 + 1 : 0;
  always @(posedge clk) re_cnt1 <= bus1.mem_re ? re_cnt1 + 1 : 0;
  assign bus4.mem_rdata = (bus4.mem_re && re_cnt4 == 3) ? pat(bus4.mem_addr) : 64'hDEAD_BEEF_DEAD_BEEF;
  assign bus1.mem_rdata = (bus1.mem_re && re_cnt1 == 0) ? pat(bus1.mem_addr) : 64'hDEAD_BEEF_DEAD_BEEF;

  typedef struct {
    logic        is_d;
    logic        we;
    logic [13:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rd;
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One isolated transaction on the MEM_LAT=4 instance, starting in an IDLE cycle.
  task automatic run_txn(input vec_t v, input string tag);
    logic wr;
    wr = v.is_d && v.we;
    if (v.is_d) begin
      bus4.d_req = 1'b1; bus4.d_we = v.we; bus4.d_addr = v.addr; bus4.d_wdata = v.wdata;
    end else begin
      bus4.i_req = 1'b1; bus4.i_addr = v.addr;
    end
    chk({tag, " idle busy"}, 64'(bus4.busy), 64'd0);
    for (int c = 1; c <= 4; c++) begin
      step();
      chk($sformatf("%s c%0d mem_re", tag, c), 64'(bus4.mem_re), 64'(!wr));
      chk($sformatf("%s c%0d mem_we", tag, c), 64'(bus4.mem_we), 64'(wr));
      chk($sformatf("%s c%0d mem_addr", tag, c), 64'(bus4.mem_addr), 64'(v.addr));
      if (wr) chk($sformatf("%s c%0d mem_wdata", tag, c), bus4.mem_wdata, v.wdata);
      chk($sformatf("%s c%0d rdy", tag, c), 64'({bus4.i_rdy, bus4.d_rdy}), 64'd0);
    end
    step();
    chk({tag, " done rdy"}, 64'({bus4.i_rdy, bus4.d_rdy}), 64'({!v.is_d, v.is_d}));
    chk({tag, " done rd_data"}, bus4.rd_data, v.exp_rd);
    chk({tag, " done cmd"}, 64'({bus4.mem_re, bus4.mem_we}), 64'd0);
    chk({tag, " done busy"}, 64'(bus4.busy), 64'd1);
    bus4.i_req = 1'b0;
    bus4.d_req = 1'b0;
    step();
    chk({tag, " after busy"}, 64'(bus4.busy), 64'd0);
    chk({tag, " after rdy"}, 64'({bus4.i_rdy, bus4.d_rdy}), 64'd0);
  endtask

  initial begin
    int   rdy_seen;
    vec_t v;
    checks   = 0;
    failures = 0;

    vecs[0] = '{is_d: 1'b0, we: 1'b0, addr: 14'h0002, wdata: 64'h0,                   exp_rd: 64'h1112_C4FF_0332_0000};
    vecs[1] = '{is_d: 1'b1, we: 1'b1, addr: 14'h3FFF, wdata: 64'hAAAA_5555_FFFF_0000, exp_rd: 64'h1112_C4FF_0332_0000};
    vecs[2] = '{is_d: 1'b1, we: 1'b0, addr: 14'h0001, wdata: 64'h0,                   exp_rd: 64'h8001_4001_C001_0001};
    vecs[3] = '{is_d: 1'b0, we: 1'b0, addr: 14'h3FFF, wdata: 64'h0,                   exp_rd: 64'hBFFF_7FFF_FFFF_3FFF};
    vecs[4] = '{is_d: 1'b1, we: 1'b1, addr: 14'h0000, wdata: 64'h0123_4567_89AB_CDEF, exp_rd: 64'hBFFF_7FFF_FFFF_3FFF};

    rst = 1'b1;
    bus4.i_req = 1'b0; bus4.i_addr = '0; bus4.d_req = 1'b0; bus4.d_we = 1'b0;
    bus4.d_addr = '0; bus4.d_wdata = '0;
    bus1.i_req = 1'b0; bus1.i_addr = '0; bus1.d_req = 1'b0; bus1.d_we = 1'b0;
    bus1.d_addr = '0; bus1.d_wdata = '0;
    step();
    step();
    chk("reset rdy", 64'({bus4.i_rdy, bus4.d_rdy}), 64'd0);
    chk("reset cmd", 64'({bus4.mem_re, bus4.mem_we}), 64'd0);
    chk("reset busy", 64'(bus4.busy), 64'd0);
    chk("reset rd_data", bus4.rd_data, 64'd0);
    chk("reset mem_addr", 64'(bus4.mem_addr), 64'd0);
    chk("reset mem_wdata", bus4.mem_wdata, 64'd0);
    chk("reset lat1 busy", 64'(bus1.busy), 64'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 5; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Reset in cycle 2 of an I read: abandoned, no rdy, then a clean retry.
    bus4.i_req = 1'b1; bus4.i_addr = 14'h0009;
    step();
    chk("abort c1 mem_re", 64'(bus4.mem_re), 64'd1);
    step();
    rst = 1'b1;
    bus4.i_req = 1'b0;
    step();
    chk("abort c3 mem_re", 64'(bus4.mem_re), 64'd0);
    chk("abort c3 busy", 64'(bus4.busy), 64'd0);
    chk("abort c3 i_rdy", 64'(bus4.i_rdy), 64'd0);
    rst = 1'b0;
    rdy_seen = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (bus4.i_rdy) rdy_seen++;
    end
    chk("abort no i_rdy", 64'(rdy_seen), 64'd0);
    v = '{is_d: 1'b0, we: 1'b0, addr: 14'h0009, wdata: 64'h0, exp_rd: 64'h8009_4009_C009_0009};
    run_txn(v, "retry");

    // Four ties right after reset alternate D, I, D, I.
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus4.i_req = 1'b1; bus4.i_addr = 14'h0006;
    bus4.d_req = 1'b1; bus4.d_we = 1'b0; bus4.d_addr = 14'h0005;
    for (int g = 0; g < 4; g++) begin
      step();
      chk($sformatf("tie%0d mem_addr", g), 64'(bus4.mem_addr), (g % 2 == 0) ? 64'h5 : 64'h6);
      chk($sformatf("tie%0d mem_re", g), 64'(bus4.mem_re), 64'd1);
      step(); step(); step();
      step();
      chk($sformatf("tie%0d rdy", g), 64'({bus4.i_rdy, bus4.d_rdy}), (g % 2 == 0) ? 64'd1 : 64'd2);
      chk($sformatf("tie%0d rd_data", g), bus4.rd_data,
          (g % 2 == 0) ? 64'h8005_4005_C005_0005 : 64'h8006_4006_C006_0006);
      if (g == 3) begin
        bus4.i_req = 1'b0;
        bus4.d_req = 1'b0;
      end
      step();
    end
    chk("tie end busy", 64'(bus4.busy), 64'd0);

    // I reissues through i_rdy while D waits: D is served next.
    bus4.i_req = 1'b1; bus4.i_addr = 14'h000A;
    step();
    chk("b2b I mem_addr", 64'(bus4.mem_addr), 64'hA);
    step();
    bus4.d_req = 1'b1; bus4.d_we = 1'b1; bus4.d_addr = 14'h000B;
    bus4.d_wdata = 64'hFEED_0000_BEEF_1111;
    step(); step(); step();
    chk("b2b I rdy", 64'(bus4.i_rdy), 64'd1);
    step();
    chk("b2b idle busy", 64'(bus4.busy), 64'd0);
    step();
    chk("b2b D mem_addr", 64'(bus4.mem_addr), 64'hB);
    chk("b2b D cmd", 64'({bus4.mem_re, bus4.mem_we}), 64'd1);
    chk("b2b D mem_wdata", bus4.mem_wdata, 64'hFEED_0000_BEEF_1111);
    step(); step(); step();
    step();
    chk("b2b D rdy", 64'({bus4.i_rdy, bus4.d_rdy}), 64'd1);
    chk("b2b D rd_data", bus4.rd_data, 64'h800A_400A_C00A_000A);
    bus4.d_req = 1'b0;
    step();
    step();
    chk("b2b I2 mem_addr", 64'(bus4.mem_addr), 64'hA);
    step(); step(); step();
    step();
    chk("b2b I2 rdy", 64'({bus4.i_rdy, bus4.d_rdy}), 64'd2);
    bus4.i_req = 1'b0;
    step();
    chk("b2b end busy", 64'(bus4.busy), 64'd0);

    // MEM_LAT=1 build: single D read.
    bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 14'h0010;
    step();
    chk("lat1 c1 mem_re", 64'(bus1.mem_re), 64'd1);
    chk("lat1 c1 mem_addr", 64'(bus1.mem_addr), 64'h10);
    chk("lat1 c1 d_rdy", 64'(bus1.d_rdy), 64'd0);
    step();
    chk("lat1 c2 mem_re", 64'(bus1.mem_re), 64'd0);
    chk("lat1 c2 d_rdy", 64'(bus1.d_rdy), 64'd1);
    chk("lat1 c2 rd_data", bus1.rd_data, 64'h8010_4010_C010_0010);
    bus1.d_req = 1'b0;
    step();
    chk("lat1 c3 busy", 64'(bus1.busy), 64'd0);
    chk("lat1 c3 d_rdy", 64'(bus1.d_rdy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences the single-ported unified main memory behind the instruction store and shares it between two requesters: the I-cache miss/fill controller, which only reads, and the D-cache miss/write-back controller, which reads and writes. Each access is one 4-word (64-bit) block over a fixed-latency memory. The block sits between the two cache controllers and the memory array. It owns the memory command bus and the round-robin grant decision.

## Interface
Parameters:
- MEM_LAT, 4, memory access latency in cycles (≥1); command held this many cycles
- BLK_AW, 14, block address width (16-bit word address minus 2 word-offset bits)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  I-cache block read request; held until i_rdy
- i_addr  in  BLK_AW  I-cache block address; stable while i_req
- i_rdy  out  1  one-cycle pulse: I read complete, rd_data valid
- d_req  in  1  D-cache request; held until d_rdy
- d_we  in  1  1 = block write-back, 0 = block read; stable while d_req
- d_addr  in  BLK_AW  D-cache block address
- d_wdata  in  64  write-back block data
- d_rdy  out  1  one-cycle pulse: D access complete (rd_data valid for reads)
- rd_data  out  64  registered read block, shared by both requesters
- mem_re  out  1  memory read command
- mem_we  out  1  memory write command
- mem_addr  out  BLK_AW  memory block address
- mem_wdata  out  64  memory write data
- mem_rdata  in  64  memory read data, valid in the last cycle of a read command
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, IREAD, DREAD, DWRITE, DONE. Reset → IDLE.
- IDLE behaviour:
  - Only i_req: next state IREAD.
  - Only d_req: next state DREAD or DWRITE, chosen by d_we.
  - Both: grant the requester that was not granted last. The last_grant register resets to I, so D wins the first tie.
  - Neither: stay.
- On grant, latch the address (and d_wdata for writes) into internal registers, set last_grant and owner, and clear cnt.
- IREAD/DREAD: mem_re=1. DWRITE: mem_we=1. mem_addr and mem_wdata come from the latched registers. cnt increments each cycle. When cnt==MEM_LAT-1, the next state is DONE. For reads, mem_rdata is captured into rd_data at that same edge.
- DONE: pulse the owner's rdy for exactly one cycle; next state IDLE. Requests are not sampled in DONE.
- Requester contract: deassert req at the edge where its rdy is high, unless it is issuing a new request. A still-high req in the following IDLE cycle is treated as a new request.
- mem_re and mem_we are never both high. Both are low in IDLE and DONE.
- rd_data holds its value until the next read capture. Write-backs do not modify it.
- cnt is $clog2(MEM_LAT+1) bits wide and never wraps within a transaction.

## Timing
- Reset values: i_rdy=d_rdy=mem_re=mem_we=busy=0; rd_data=0; mem_addr=0; mem_wdata=0; last_grant=I.
- Request sampled in IDLE at cycle 0. The command is driven in cycles 1..MEM_LAT. rdy pulses in cycle MEM_LAT+1. The state returns to IDLE in cycle MEM_LAT+2.
- Minimum spacing between grants is MEM_LAT+2 cycles. A waiting requester is granted in the IDLE cycle right after the other requester's DONE.
- Reset asserted mid-transaction: IDLE on the next cycle. The command drops immediately, no rdy is issued, and the in-flight access is abandoned. last_grant returns to I.
- A request arriving while busy waits. No request is lost, provided the requester keeps it held.

## Structure
- Shared package mem_pkg holds: the state enum (IDLE, IREAD, DREAD, DWRITE, DONE), the owner encoding (OWN_I=0, OWN_D=1), the BLK_W=64 block width constant, and the default MEM_LAT.
- Single module with no sub-modules. The FSM, counter and latches are all inline.

## Test plan
- Single I read, MEM_LAT=4: i_req, i_addr=0x0002 at cycle 0 → mem_re high cycles 1–4 with mem_addr=0x0002; memory returns 0x1112_C4FF_0332_0000 in cycle 4 → i_rdy=1 and rd_data matches in cycle 5; busy low in cycle 6.
- D write-back: d_req, d_we=1, d_addr=0x3FFF, d_wdata=0xAAAA_5555_FFFF_0000 → mem_we high 4 cycles with that addr/data; mem_re never high; d_rdy in cycle 5; rd_data unchanged.
- Simultaneous i_req and d_req after reset → D granted first; I granted in the IDLE cycle after d_rdy; the next simultaneous tie goes to D again (alternation check over 4 ties).
- Back-to-back: I holds i_req through i_rdy (reissue) while d_req is pending → D is granted next, not I.
- Reset asserted in cycle 2 of an IREAD → cycle 3: IDLE, mem_re=0, busy=0, no i_rdy ever issued; a re-request completes normally.
- MEM_LAT=1 build: single D read → mem_re high in cycle 1 only, d_rdy in cycle 2.
